// File: rtl/palindrome_pkg.sv
// Shared definitions for the palindrome checker path and its serial front end.
package palindrome_pkg;

    localparam int WORD_W = 8;

    typedef enum logic {IDLE, COLLECT} coll_state_t;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/serial_word_collector.sv
// Deserialises an MSB-first bit stream into WIDTH-bit words behind a one-deep valid/ready output register.
module serial_word_collector
    import palindrome_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overrun,
    input  logic             clr_overrun,
    output logic [CNT_W-1:0] word_count
);

    localparam int BC_W = $clog2(WIDTH + 1);
    localparam logic [BC_W-1:0] LAST_IDX = BC_W'(WIDTH - 1);

    coll_state_t      state;
    logic [BC_W-1:0]  bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] word_next;
    logic             complete;
    logic             handshake;

    assign word_next = {shreg[WIDTH-2:0], bit_in};
    // frame_start on the final bit's edge suppresses completion
    assign complete  = bit_valid && !frame_start && (state == COLLECT) && (bit_cnt == LAST_IDX);
    assign handshake = data_valid && data_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (frame_start) begin
            if (bit_valid) begin
                state   <= COLLECT;
                bit_cnt <= BC_W'(1);
                shreg   <= {{(WIDTH-1){1'b0}}, bit_in};
            end else begin
                state   <= IDLE;
                bit_cnt <= '0;
                shreg   <= '0;
            end
        end else if (bit_valid) begin
            shreg <= word_next;
            if (complete) begin
                state   <= IDLE;
                bit_cnt <= '0;
            end else begin
                state   <= COLLECT;
                bit_cnt <= bit_cnt + BC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else if (complete && (!data_valid || data_ready)) begin
            data_out   <= word_next;
            data_valid <= 1'b1;
        end else if (handshake && !complete) begin
            data_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (complete && data_valid && !data_ready) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count <= '0;
        end else if (handshake) begin
            word_count <= word_count + CNT_W'(1);
        end
    end

endmodule
